float_quadratic_roots: RTL and testbench



---
 rtl/float_quadratic_roots.sv | 258 +++++++++++++++++++++++++
 tb/tb_float_quadratic_roots.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/float_quadratic_roots.sv
// FP64 quadratic root stage: x0/x1 = (-b +/- sqrt(D)) / (2a), plus its arithmetic wrappers.

// Generic FP64 operator with the common handshake; fixed latency, one op in flight.
module f_unit #(
  parameter int unsigned FLEN    = 64,
  parameter int unsigned Op      = 0,
  parameter int unsigned Latency = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic            up_valid,
  output logic [FLEN-1:0] res,
  output logic            down_valid,
  output logic            busy,
  output logic            error
);
  real                ra, rb, rr;
  logic [Latency-1:0] pipe;
  logic [FLEN-1:0]    hold;

  // Evaluate the selected IEEE-754 double operation (round to nearest even)
  always_comb begin
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    case (Op)
      0:       rr = ra * rb;
      1:       rr = ra + rb;
      2:       rr = ra - rb;
      3:       rr = $sqrt(ra);
      default: rr = ra / rb;
    endcase
  end

  // Capture the result at issue and walk the strobe down the latency line
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
      hold <= '0;
    end else begin
      pipe <= (pipe << 1) | Latency'(up_valid);
      if (up_valid) hold <= $realtobits(rr);
    end
  end

  assign res        = hold;
  assign down_valid = pipe[Latency-1];
  assign busy       = |pipe;
  // Inf or NaN results are flagged as errors
  assign error      = down_valid & (&hold[FLEN-2:FLEN-12]);
endmodule

module f_mult #(parameter int unsigned FLEN = 64, parameter int unsigned Latency = 3) (
  input  logic clk, input logic rst, input logic [FLEN-1:0] a, input logic [FLEN-1:0] b,
  input  logic up_valid, output logic [FLEN-1:0] res, output logic down_valid,
  output logic busy, output logic error
);
  f_unit #(.FLEN(FLEN), .Op(0), .Latency(Latency)) u_unit (.clk(clk), .rst(rst), .a(a), .b(b),
    .up_valid(up_valid), .res(res), .down_valid(down_valid), .busy(busy), .error(error));
endmodule

module f_add #(parameter int unsigned FLEN = 64, parameter int unsigned Latency = 4) (
  input  logic clk, input logic rst, input logic [FLEN-1:0] a, input logic [FLEN-1:0] b,
  input  logic up_valid, output logic [FLEN-1:0] res, output logic down_valid,
  output logic busy, output logic error
);
  f_unit #(.FLEN(FLEN), .Op(1), .Latency(Latency)) u_unit (.clk(clk), .rst(rst), .a(a), .b(b),
    .up_valid(up_valid), .res(res), .down_valid(down_valid), .busy(busy), .error(error));
endmodule

module f_sub #(parameter int unsigned FLEN = 64, parameter int unsigned Latency = 4) (
  input  logic clk, input logic rst, input logic [FLEN-1:0] a, input logic [FLEN-1:0] b,
  input  logic up_valid, output logic [FLEN-1:0] res, output logic down_valid,
  output logic busy, output logic error
);
  f_unit #(.FLEN(FLEN), .Op(2), .Latency(Latency)) u_unit (.clk(clk), .rst(rst), .a(a), .b(b),
    .up_valid(up_valid), .res(res), .down_valid(down_valid), .busy(busy), .error(error));
endmodule

module f_sqrt #(parameter int unsigned FLEN = 64, parameter int unsigned Latency = 6) (
  input  logic clk, input logic rst, input logic [FLEN-1:0] a, input logic [FLEN-1:0] b,
  input  logic up_valid, output logic [FLEN-1:0] res, output logic down_valid,
  output logic busy, output logic error
);
  f_unit #(.FLEN(FLEN), .Op(3), .Latency(Latency)) u_unit (.clk(clk), .rst(rst), .a(a), .b(b),
    .up_valid(up_valid), .res(res), .down_valid(down_valid), .busy(busy), .error(error));
endmodule

module f_div #(parameter int unsigned FLEN = 64, parameter int unsigned Latency = 8) (
  input  logic clk, input logic rst, input logic [FLEN-1:0] a, input logic [FLEN-1:0] b,
  input  logic up_valid, output logic [FLEN-1:0] res, output logic down_valid,
  output logic busy, output logic error
);
  f_unit #(.FLEN(FLEN), .Op(4), .Latency(Latency)) u_unit (.clk(clk), .rst(rst), .a(a), .b(b),
    .up_valid(up_valid), .res(res), .down_valid(down_valid), .busy(busy), .error(error));
endmodule

module float_quadratic_roots #(
  parameter int unsigned FLEN    = 64,
  parameter int unsigned SqrtLat = 6,
  parameter int unsigned MultLat = 3,
  parameter int unsigned SubLat  = 4,
  parameter int unsigned AddLat  = 4,
  parameter int unsigned DivLat  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_vld,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [FLEN-1:0] d,
  input  logic            d_err,
  output logic            res_vld,
  output logic [FLEN-1:0] x0,
  output logic [FLEN-1:0] x1,
  output logic            no_real,
  output logic            err,
  output logic            busy
);
  typedef enum logic [2:0] {
    StIdle, StWaitSqrt, StWait2a, StWaitN0, StWaitN1, StWaitX0, StWaitX1
  } state_e;

  localparam logic [FLEN-1:0] TwoFp = 64'h4000_0000_0000_0000;

  state_e          state_q, state_d;
  logic [FLEN-1:0] a_q, b_q, s_q, t_q, n0_q, n1_q, xc_q;
  logic            sqrt_go, mult_go, sub_go, add_go, div_go;
  logic            done_ok, done_err, done_neg;
  logic            in_bad, d_neg;
  logic [FLEN-1:0] sqrt_res, mult_res, sub_res, add_res, div_res, div_num;
  logic            sqrt_dv, mult_dv, sub_dv, add_dv, div_dv;
  logic            sqrt_er, mult_er, sub_er, add_er, div_er;
  logic            sqrt_busy, mult_busy, sub_busy, add_busy, div_busy;

  // Argument screening on the acceptance cycle; -0 is zero, not negative
  always_comb begin
    in_bad = d_err | (&a[FLEN-2:FLEN-12]) | (&b[FLEN-2:FLEN-12]) | (&d[FLEN-2:FLEN-12]) |
             (a[FLEN-2:0] == '0);
    d_neg  = d[FLEN-1] & (d[FLEN-2:0] != '0);
  end

  // Sequencer: each down_valid retires one op and issues the next in the same cycle
  always_comb begin
    state_d  = state_q;
    sqrt_go  = 1'b0;
    mult_go  = 1'b0;
    sub_go   = 1'b0;
    add_go   = 1'b0;
    div_go   = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    done_neg = 1'b0;
    case (state_q)
      StIdle: begin
        if (arg_vld) begin
          if (in_bad)      done_err = 1'b1;
          else if (d_neg)  done_neg = 1'b1;
          else begin
            sqrt_go = 1'b1;
            state_d = StWaitSqrt;
          end
        end
      end
      StWaitSqrt: if (sqrt_dv) begin
        if (sqrt_er) begin done_err = 1'b1; state_d = StIdle; end
        else begin mult_go = 1'b1; state_d = StWait2a; end
      end
      StWait2a: if (mult_dv) begin
        if (mult_er) begin done_err = 1'b1; state_d = StIdle; end
        else begin sub_go = 1'b1; state_d = StWaitN0; end
      end
      StWaitN0: if (sub_dv) begin
        if (sub_er) begin done_err = 1'b1; state_d = StIdle; end
        else begin add_go = 1'b1; state_d = StWaitN1; end
      end
      StWaitN1: if (add_dv) begin
        if (add_er) begin done_err = 1'b1; state_d = StIdle; end
        else begin div_go = 1'b1; state_d = StWaitX0; end
      end
      StWaitX0: if (div_dv) begin
        if (div_er) begin done_err = 1'b1; state_d = StIdle; end
        else begin div_go = 1'b1; state_d = StWaitX1; end
      end
      StWaitX1: if (div_dv) begin
        if (div_er) done_err = 1'b1;
        else        done_ok  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, operand/intermediate registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      t_q     <= '0;
      n0_q    <= '0;
      n1_q    <= '0;
      xc_q    <= '0;
      res_vld <= 1'b0;
      x0      <= '0;
      x1      <= '0;
      no_real <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != StIdle);
      res_vld <= done_ok | done_err | done_neg;
      if (done_ok | done_err | done_neg) begin
        err     <= done_err;
        no_real <= done_neg;
      end
      if (done_ok) begin
        x0 <= xc_q;
        x1 <= div_res;
      end
      if (state_q == StIdle && arg_vld) begin
        a_q <= a;
        b_q <= b;
      end
      if (sqrt_dv) s_q <= sqrt_res;
      if (mult_dv) t_q <= mult_res;
      if (sub_dv)  n0_q <= sub_res;
      // n1 = -(b + s)
      if (add_dv)  n1_q <= {~add_res[FLEN-1], add_res[FLEN-2:0]};
      if (div_dv && state_q == StWaitX0) xc_q <= div_res;
    end
  end

  assign div_num = (state_q == StWaitN1) ? n0_q : n1_q;

  f_sqrt #(.FLEN(FLEN), .Latency(SqrtLat)) u_sqrt (
    .clk(clk), .rst(rst), .a(d), .b('0), .up_valid(sqrt_go), .res(sqrt_res),
    .down_valid(sqrt_dv), .busy(sqrt_busy), .error(sqrt_er));
  f_mult #(.FLEN(FLEN), .Latency(MultLat)) u_mult (
    .clk(clk), .rst(rst), .a(TwoFp), .b(a_q), .up_valid(mult_go), .res(mult_res),
    .down_valid(mult_dv), .busy(mult_busy), .error(mult_er));
  f_sub #(.FLEN(FLEN), .Latency(SubLat)) u_sub (
    .clk(clk), .rst(rst), .a(s_q), .b(b_q), .up_valid(sub_go), .res(sub_res),
    .down_valid(sub_dv), .busy(sub_busy), .error(sub_er));
  f_add #(.FLEN(FLEN), .Latency(AddLat)) u_add (
    .clk(clk), .rst(rst), .a(b_q), .b(s_q), .up_valid(add_go), .res(add_res),
    .down_valid(add_dv), .busy(add_busy), .error(add_er));
  f_div #(.FLEN(FLEN), .Latency(DivLat)) u_div (
    .clk(clk), .rst(rst), .a(div_num), .b(t_q), .up_valid(div_go), .res(div_res),
    .down_valid(div_dv), .busy(div_busy), .error(div_er));

  // Never more than one arithmetic unit in flight
  assert property (@(posedge clk) disable iff (rst)
    $onehot0({sqrt_busy, mult_busy, sub_busy, add_busy, div_busy}));
endmodule

// File: tb/tb_float_quadratic_roots.sv
// Randomised and directed checks of float_quadratic_roots against a real-arithmetic model.
module tb_float_quadratic_roots;
  localparam int SQ = 6, MU = 3, SB = 4, AD = 4, DV = 8;
  localparam int LAT = SQ + MU + SB + AD + 2 * DV + 1;
  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst, arg_vld, d_err;
  logic [63:0] a, b, d;
  logic        res_vld, no_real, err, busy;
  logic [63:0] x0, x1;

  int total = 0;
  int bad   = 0;
  logic [63:0] last_x0 = '0, last_x1 = '0;

  float_quadratic_roots #(.FLEN(64), .SqrtLat(SQ), .MultLat(MU), .SubLat(SB), .AddLat(AD),
    .DivLat(DV)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .a(a), .b(b), .d(d), .d_err(d_err),
    .res_vld(res_vld), .x0(x0), .x1(x1), .no_real(no_real), .err(err), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit special(logic [63:0] v);
    return v[62:52] == 11'h7ff;
  endfunction

  // Reference: roots from the quadratic formula in double precision
  task automatic model(input logic [63:0] ma, mb, md, input bit me, output bit e,
                       output bit nr, output logic [63:0] r0, r1, output int lat);
    real s, t, n0, n1, q0, q1, rb;
    e = 0; nr = 0; r0 = last_x0; r1 = last_x1; lat = 1;
    if (me || special(ma) || special(mb) || special(md) || ma[62:0] == 0) begin
      e = 1; return;
    end
    if (md[63] && md[62:0] != 0) begin nr = 1; return; end
    rb = $bitstoreal(mb);
    s  = $sqrt($bitstoreal(md));
    t  = 2.0 * $bitstoreal(ma);
    n0 = s - rb;
    n1 = $bitstoreal($realtobits(rb + s) ^ 64'h8000_0000_0000_0000);
    q0 = n0 / t;
    q1 = n1 / t;
    lat = LAT;
    if (special($realtobits(t)) || special($realtobits(n0)) || special($realtobits(n1)) ||
        special($realtobits(q0)) || special($realtobits(q1))) begin
      e = 1; lat = 0; return;
    end
    r0 = $realtobits(q0);
    r1 = $realtobits(q1);
  endtask

  // Present one argument set (caller sits just after a negedge) and wait for res_vld
  task automatic do_op(input logic [63:0] ia, ib, id, input bit ie, output int cyc,
                       output bit saw_busy);
    a = ia; b = ib; d = id; d_err = ie; arg_vld = 1'b1;
    cyc = 0; saw_busy = 0;
    forever begin
      @(negedge clk);
      arg_vld = 1'b0; d_err = 1'b0;
      cyc++;
      if (res_vld || cyc >= LIMIT) break;
      if (busy) saw_busy = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; arg_vld = 1'b0; d_err = 1'b0; a = '0; b = '0; d = '0;
    repeat (3) @(negedge clk);
    total++; if (res_vld !== 1'b0) begin bad++; $display("FAIL rst_res_vld: got %b want 0", res_vld); end
    total++; if (x0 !== 64'h0) begin bad++; $display("FAIL rst_x0: got %h want 0", x0); end
    total++; if (x1 !== 64'h0) begin bad++; $display("FAIL rst_x1: got %h want 0", x1); end
    total++; if (no_real !== 1'b0) begin bad++; $display("FAIL rst_no_real: got %b want 0", no_real); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_roots;
    logic [63:0] ta [3], tb_ [3], td [3], e0 [3], e1 [3];
    int cyc; bit sb;
    ta[0] = 64'h3FF0_0000_0000_0000; tb_[0] = 64'hC008_0000_0000_0000; td[0] = 64'h3FF0_0000_0000_0000;
    e0[0] = 64'h4000_0000_0000_0000; e1[0] = 64'h3FF0_0000_0000_0000;
    ta[1] = 64'h3FF0_0000_0000_0000; tb_[1] = 64'h4000_0000_0000_0000; td[1] = 64'h0;
    e0[1] = 64'hBFF0_0000_0000_0000; e1[1] = 64'hBFF0_0000_0000_0000;
    ta[2] = 64'h3FF0_0000_0000_0000; tb_[2] = 64'h4000_0000_0000_0000; td[2] = 64'h8000_0000_0000_0000;
    e0[2] = 64'hBFF0_0000_0000_0000; e1[2] = 64'hBFF0_0000_0000_0000;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb_[i], td[i], 1'b0, cyc, sb);
      total++; if (cyc !== LAT) begin bad++; $display("FAIL roots%0d_latency: got %0d want %0d", i, cyc, LAT); end
      total++; if (x0 !== e0[i]) begin bad++; $display("FAIL roots%0d_x0: got %h want %h", i, x0, e0[i]); end
      total++; if (x1 !== e1[i]) begin bad++; $display("FAIL roots%0d_x1: got %h want %h", i, x1, e1[i]); end
      total++; if ({err, no_real} !== 2'b00) begin bad++; $display("FAIL roots%0d_flags: got %b want 00", i, {err, no_real}); end
      total++; if (sb !== 1'b1) begin bad++; $display("FAIL roots%0d_busy_seen: got %b want 1", i, sb); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL roots%0d_busy_at_res: got %b want 0", i, busy); end
      last_x0 = e0[i]; last_x1 = e1[i];
    end
  endtask

  task automatic test_no_real;
    int cyc; bit sb;
    do_op(64'h3FF0_0000_0000_0000, 64'h0, 64'hC010_0000_0000_0000, 1'b0, cyc, sb);
    total++; if (cyc !== 1) begin bad++; $display("FAIL noreal_latency: got %0d want 1", cyc); end
    total++; if ({err, no_real} !== 2'b01) begin bad++; $display("FAIL noreal_flags: got %b want 01", {err, no_real}); end
    total++; if (x0 !== last_x0 || x1 !== last_x1) begin bad++; $display("FAIL noreal_hold: got %h %h want %h %h", x0, x1, last_x0, last_x1); end
    total++; if (sb !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL noreal_busy: got %b%b want 00", sb, busy); end
  endtask

  task automatic test_invalid;
    logic [63:0] ia [4], ib [4];
    bit ie [4];
    int cyc; bit sb;
    ia[0] = 64'h0;                   ib[0] = 64'h3FF0_0000_0000_0000; ie[0] = 0;
    ia[1] = 64'h3FF0_0000_0000_0000; ib[1] = 64'h7FF0_0000_0000_0000; ie[1] = 0;
    ia[2] = 64'h3FF0_0000_0000_0000; ib[2] = 64'h3FF0_0000_0000_0000; ie[2] = 1;
    ia[3] = 64'h8000_0000_0000_0000; ib[3] = 64'h3FF0_0000_0000_0000; ie[3] = 0;
    for (int i = 0; i < 4; i++) begin
      do_op(ia[i], ib[i], 64'h3FF0_0000_0000_0000, ie[i], cyc, sb);
      total++; if (cyc !== 1) begin bad++; $display("FAIL inv%0d_latency: got %0d want 1", i, cyc); end
      total++; if ({err, no_real} !== 2'b10) begin bad++; $display("FAIL inv%0d_flags: got %b want 10", i, {err, no_real}); end
      total++; if (x0 !== last_x0 || x1 !== last_x1) begin bad++; $display("FAIL inv%0d_hold: got %h %h want %h %h", i, x0, x1, last_x0, last_x1); end
      total++; if (sb !== 1'b0) begin bad++; $display("FAIL inv%0d_busy: got %b want 0", i, sb); end
    end
  endtask

  task automatic test_random;
    real ra, rb, rc;
    logic [63:0] ia, ib, id, r0, r1;
    bit ie, e, nr, sb;
    int cyc, lat;
    for (int i = 0; i < 24; i++) begin
      ra = real'(int'($urandom_range(0, 400)) - 200) / 8.0;
      rb = real'(int'($urandom_range(0, 400)) - 200) / 8.0;
      rc = real'(int'($urandom_range(0, 400)) - 200) / 8.0;
      ia = $realtobits(ra); ib = $realtobits(rb);
      id = $realtobits(rb * rb - 4.0 * ra * rc);
      ie = ($urandom_range(0, 9) == 0);
      model(ia, ib, id, ie, e, nr, r0, r1, lat);
      do_op(ia, ib, id, ie, cyc, sb);
      total++; if ({err, no_real} !== {e, nr}) begin bad++; $display("FAIL rnd%0d_flags: got %b want %b", i, {err, no_real}, {e, nr}); end
      total++; if (x0 !== r0) begin bad++; $display("FAIL rnd%0d_x0: got %h want %h", i, x0, r0); end
      total++; if (x1 !== r1) begin bad++; $display("FAIL rnd%0d_x1: got %h want %h", i, x1, r1); end
      total++; if ((lat != 0 && cyc !== lat) || cyc >= LIMIT) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, cyc, lat); end
      last_x0 = r0; last_x1 = r1;
    end
  endtask

  task automatic test_busy_ignore;
    logic [63:0] r0, r1;
    bit e, nr;
    int cyc, lat, extra;
    model(64'h4000_0000_0000_0000, 64'hC014_0000_0000_0000, 64'h4022_0000_0000_0000, 1'b0,
          e, nr, r0, r1, lat);
    a = 64'h4000_0000_0000_0000; b = 64'hC014_0000_0000_0000; d = 64'h4022_0000_0000_0000;
    d_err = 1'b0; arg_vld = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      arg_vld = (cyc == 4 || cyc == 15);
      a = 64'h3FF0_0000_0000_0000; b = 64'h4024_0000_0000_0000; d = 64'h4059_0000_0000_0000;
      d_err = (cyc == 15);
      if (res_vld || cyc >= LIMIT) break;
    end
    arg_vld = 1'b0; d_err = 1'b0;
    total++; if (cyc !== LAT) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", cyc, LAT); end
    total++; if (x0 !== r0) begin bad++; $display("FAIL ignore_x0: got %h want %h", x0, r0); end
    total++; if (x1 !== r1) begin bad++; $display("FAIL ignore_x1: got %h want %h", x1, r1); end
    last_x0 = r0; last_x1 = r1;
    extra = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (res_vld) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL ignore_extra_res: got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] r0, r1;
    bit e, nr, sb;
    int cyc, lat;
    model(64'hBFF0_0000_0000_0000, 64'h4010_0000_0000_0000, 64'h4030_0000_0000_0000, 1'b0,
          e, nr, r0, r1, lat);
    do_op(64'h3FF0_0000_0000_0000, 64'hC008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, cyc, sb);
    // Issue again in the very res_vld cycle
    do_op(64'hBFF0_0000_0000_0000, 64'h4010_0000_0000_0000, 64'h4030_0000_0000_0000, 1'b0, cyc, sb);
    total++; if (cyc !== LAT) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", cyc, LAT); end
    total++; if (x0 !== r0 || x1 !== r1) begin bad++; $display("FAIL b2b_roots: got %h %h want %h %h", x0, x1, r0, r1); end
    last_x0 = r0; last_x1 = r1;
  endtask

  task automatic test_reset_mid;
    logic [63:0] r0, r1;
    bit e, nr, sb;
    int cyc, lat, seen;
    a = 64'h3FF0_0000_0000_0000; b = 64'hC008_0000_0000_0000; d = 64'h3FF0_0000_0000_0000;
    d_err = 1'b0; arg_vld = 1'b1;
    @(negedge clk);
    arg_vld = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (res_vld !== 1'b0) begin bad++; $display("FAIL midrst_res_vld: got %b want 0", res_vld); end
    total++; if (x0 !== 64'h0 || x1 !== 64'h0) begin bad++; $display("FAIL midrst_x: got %h %h want 0 0", x0, x1); end
    total++; if ({no_real, err, busy} !== 3'b000) begin bad++; $display("FAIL midrst_flags: got %b want 000", {no_real, err, busy}); end
    rst = 1'b0;
    last_x0 = '0; last_x1 = '0;
    seen = 0;
    repeat (LAT + 10) begin
      @(negedge clk);
      if (res_vld) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_res: got %0d want 0", seen); end
    model(64'h4008_0000_0000_0000, 64'h4018_0000_0000_0000, 64'h4042_0000_0000_0000, 1'b0,
          e, nr, r0, r1, lat);
    do_op(64'h4008_0000_0000_0000, 64'h4018_0000_0000_0000, 64'h4042_0000_0000_0000, 1'b0, cyc, sb);
    total++; if (cyc !== LAT) begin bad++; $display("FAIL midrst_after_latency: got %0d want %0d", cyc, LAT); end
    total++; if (x0 !== r0 || x1 !== r1) begin bad++; $display("FAIL midrst_after_roots: got %h %h want %h %h", x0, x1, r0, r1); end
    last_x0 = r0; last_x1 = r1;
  endtask

  initial begin
    test_reset();
    test_roots();
    test_no_real();
    test_invalid();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
